lowpass_scheduler: RTL

Time-multiplexed controller that shares one RC low-pass update datapath among `CHANNELS` audio channels of the FM transmitter. On each sample strobe it captures all channel inputs. It then steps the shared integrator through the channels, one per clock, and publishes the filtered results with a single-cycle valid pulse. It sits between the audio sample source and the pre-emphasis/modulator stage, and replaces one filter instance per channel.

---
 rtl/lowpass_pkg.sv | 27 ++
 rtl/lowpass_core.sv | 29 ++
 rtl/lowpass_scheduler.sv | 109 ++++++++++
 3 files changed

// File: rtl/lowpass_pkg.sv
// Shared types and helpers for the time-multiplexed RC low-pass scheduler.
package lowpass_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Leak shift: the integrator decays by sum >>> (BITS_OUT - BITS_IN) per update.
  function automatic int shiftOf(input int bitsOut, input int bitsIn);
    return bitsOut - bitsIn;
  endfunction

  // Clamp a wide signed value into the signed range of a bitsOut-wide word (bitsOut <= 32).
  function automatic logic signed [32:0] saturate(input logic signed [32:0] value,
                                                  input int bitsOut);
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    hi = (33'sd1 <<< (bitsOut - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (bitsOut - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/lowpass_core.sv
// Combinational single-channel RC low-pass update: next = sat(sum + (x >>> ATT) - (sum >>> SHIFT)).
module lowpass_core
  import lowpass_pkg::*;
#(
  parameter int BITS_IN     = 12,
  parameter int BITS_OUT    = 16,
  parameter int ATTENUATION = 0
) (
  input  logic signed [BITS_OUT-1:0] i_sum,
  input  logic signed [BITS_IN-1:0]  i_x,
  output logic signed [BITS_OUT-1:0] o_next
);

  localparam int SHIFT = shiftOf(BITS_OUT, BITS_IN);
  localparam int W     = BITS_OUT + 1;

  logic signed [W-1:0] w_sumExt;
  logic signed [W-1:0] w_xShift;
  logic signed [W-1:0] w_leak;
  logic signed [W-1:0] w_raw;

  // One guard bit is enough: sum - leak stays in range, and x adds at most 2^(BITS_IN-1).
  assign w_sumExt = W'(i_sum);
  assign w_xShift = W'(i_x) >>> ATTENUATION;
  assign w_leak   = w_sumExt >>> SHIFT;
  assign w_raw    = w_sumExt + w_xShift - w_leak;
  assign o_next   = BITS_OUT'(saturate(33'(w_raw), BITS_OUT));

endmodule

// File: rtl/lowpass_scheduler.sv
// Shares one lowpass_core among CHANNELS channels: capture on strobe, update one channel per clock.
module lowpass_scheduler
  import lowpass_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int BITS_IN     = 12,
  parameter int BITS_OUT    = 16,
  parameter int ATTENUATION = 0
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic                         flush,
  input  logic [CHANNELS-1:0]          chan_mask,
  input  logic                         clear_overrun,
  input  logic [CHANNELS*BITS_IN-1:0]  data_in,
  output logic [CHANNELS*BITS_OUT-1:0] data_out,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         overrun
);

  localparam int IDXW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(CHANNELS - 1);

  state_t r_state;
  state_t w_nextState;

  logic [IDXW-1:0]            r_idx;
  logic signed [BITS_IN-1:0]  r_sample [CHANNELS];
  logic signed [BITS_OUT-1:0] r_sum    [CHANNELS];
  logic signed [BITS_OUT-1:0] w_coreNext;
  logic                       r_overrun;
  logic                       w_strobe;
  logic                       w_overrunHit;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_nextState;
  end

  // Flush overrides every transition, aborting any frame without a DONE cycle.
  always_comb begin
    w_nextState = r_state;
    busy        = 1'b1;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (enable) w_nextState = UPDATE;
      end
      UPDATE: begin
        if (r_idx == LAST_IDX) w_nextState = DONE;
      end
      DONE: begin
        out_valid   = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
    if (flush) w_nextState = IDLE;
  end

  assign w_strobe     = enable && !flush && (r_state == IDLE);
  assign w_overrunHit = enable && !flush && (r_state != IDLE);

  lowpass_core #(
    .BITS_IN    (BITS_IN),
    .BITS_OUT   (BITS_OUT),
    .ATTENUATION(ATTENUATION)
  ) u_core (
    .i_sum (r_sum[r_idx]),
    .i_x   (r_sample[r_idx]),
    .o_next(w_coreNext)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_idx <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_sample[c] <= '0;
        r_sum[c]    <= '0;
      end
    end else if (flush) begin
      r_idx <= '0;
      for (int c = 0; c < CHANNELS; c++) r_sum[c] <= '0;
    end else if (w_strobe) begin
      r_idx <= '0;
      for (int c = 0; c < CHANNELS; c++) r_sample[c] <= data_in[c*BITS_IN +: BITS_IN];
    end else if (r_state == UPDATE) begin
      if (chan_mask[r_idx]) r_sum[r_idx] <= w_coreNext;
      r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDXW'(1);
    end
  end

  // A dropped strobe outranks a same-cycle clear so the event is never lost.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)          r_overrun <= 1'b0;
    else if (w_overrunHit) r_overrun <= 1'b1;
    else if (clear_overrun) r_overrun <= 1'b0;
  end

  assign overrun = r_overrun;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_out
    assign data_out[g*BITS_OUT +: BITS_OUT] = r_sum[g];
  end

endmodule
